// File: rtl/fpc_scanline_fill.sv
// rtl/fpc_scanline_fill.sv - pixel stream to scanline RAM filler paced by fpc_hdmi line/frame sync
module fpc_scanline_fill #(
    parameter int WIDTH       = 1600,
    parameter int HEIGHT      = 900,
    parameter int HBITS       = 11,
    parameter int VBITS       = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             linesync,
    input  logic             framesync,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [23:0]      pix_data,
    input  logic             pix_sof,
    output logic [HBITS-1:0] addr,
    output logic [7:0]       rdata,
    output logic [7:0]       gdata,
    output logic [7:0]       bdata,
    output logic             rwe,
    output logic             gwe,
    output logic             bwe,
    output logic             busy,
    output logic [VBITS-1:0] line_idx,
    output logic             underrun,
    output logic             sof_err,
    input  logic             clr_status
);

    typedef enum logic [1:0] {WAIT_FRAME, FILL, WAIT_LINE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ls_sync;
    logic [SYNC_STAGES-1:0] fs_sync;
    logic                   ls_prev;
    logic                   ls_s;
    logic                   fs_s;
    logic                   line_fall;
    logic                   hunt;
    logic                   hunt_err;
    logic                   we;
    logic [HBITS:0]         pix_cnt;
    logic                   accept;
    logic                   wr_beat;
    logic                   last_beat;
    logic                   bad_sof;
    logic                   set_underrun;
    logic                   set_sof_err;
    logic                   last_line;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ls_sync <= '0;
            fs_sync <= '0;
            ls_prev <= 1'b0;
        end else begin
            ls_sync <= {ls_sync[SYNC_STAGES-2:0], linesync};
            fs_sync <= {fs_sync[SYNC_STAGES-2:0], framesync};
            ls_prev <= ls_s;
        end
    end

    assign ls_s      = ls_sync[SYNC_STAGES-1];
    assign fs_s      = fs_sync[SYNC_STAGES-1];
    assign line_fall = ls_prev & ~ls_s;

    // Once aligned, an SOF beat is refused so it stays at the source head for the next frame.
    assign pix_ready    = (state == FILL) && (hunt || !pix_sof);
    assign accept       = pix_valid && pix_ready;
    assign wr_beat      = accept && (!hunt || pix_sof);
    assign last_beat    = wr_beat && (pix_cnt == (HBITS+1)'(WIDTH - 1));
    assign bad_sof      = (state == FILL) && !hunt && pix_valid && pix_sof;
    assign set_underrun = (state == FILL) && line_fall && !last_beat;
    assign set_sof_err  = ((state == FILL) && hunt && !hunt_err && accept && !pix_sof) || bad_sof;
    assign last_line    = (line_idx == VBITS'(HEIGHT - 1));

    assign rwe  = we;
    assign gwe  = we;
    assign bwe  = we;
    assign busy = (state == FILL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= WAIT_FRAME;
            hunt     <= 1'b0;
            hunt_err <= 1'b0;
            pix_cnt  <= '0;
            line_idx <= '0;
            addr     <= '0;
            rdata    <= '0;
            gdata    <= '0;
            bdata    <= '0;
            we       <= 1'b0;
            underrun <= 1'b0;
            sof_err  <= 1'b0;
        end else begin
            we       <= 1'b0;
            underrun <= set_underrun | (underrun & ~clr_status);
            sof_err  <= set_sof_err | (sof_err & ~clr_status);
            if (set_sof_err)
                hunt_err <= 1'b1;
            if (wr_beat && !set_underrun) begin
                addr  <= pix_cnt[HBITS-1:0];
                rdata <= pix_data[23:16];
                gdata <= pix_data[15:8];
                bdata <= pix_data[7:0];
                we    <= 1'b1;
            end
            case (state)
                WAIT_FRAME: begin
                    if (line_fall && fs_s) begin
                        line_idx <= '0;
                        pix_cnt  <= '0;
                        hunt     <= 1'b1;
                        hunt_err <= 1'b0;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (set_underrun) begin
                        // Abandoned line: the same edge may still arm a new frame.
                        if (fs_s) begin
                            line_idx <= '0;
                            pix_cnt  <= '0;
                            hunt     <= 1'b1;
                            hunt_err <= 1'b0;
                        end else begin
                            state <= WAIT_FRAME;
                        end
                    end else if (bad_sof) begin
                        state <= WAIT_FRAME;
                    end else if (wr_beat) begin
                        pix_cnt <= pix_cnt + 1'b1;
                        hunt    <= 1'b0;
                        if (last_beat) begin
                            if (line_fall && fs_s) begin
                                line_idx <= '0;
                                pix_cnt  <= '0;
                                hunt     <= 1'b1;
                                hunt_err <= 1'b0;
                            end else if (line_fall && !last_line) begin
                                line_idx <= line_idx + 1'b1;
                                pix_cnt  <= '0;
                            end else if (last_line) begin
                                state <= WAIT_FRAME;
                            end else begin
                                state <= WAIT_LINE;
                            end
                        end
                    end
                end
                WAIT_LINE: begin
                    if (line_fall) begin
                        pix_cnt <= '0;
                        state   <= FILL;
                        if (fs_s) begin
                            line_idx <= '0;
                            hunt     <= 1'b1;
                            hunt_err <= 1'b0;
                        end else begin
                            line_idx <= line_idx + 1'b1;
                        end
                    end
                end
                default: state <= WAIT_FRAME;
            endcase
        end
    end

endmodule

// File: tb/tb_fpc_scanline_fill.sv
// tb/tb_fpc_scanline_fill.sv - scoreboard bench for fpc_scanline_fill
module tb_fpc_scanline_fill;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        linesync;
    logic        framesync;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_data;
    logic        pix_sof;
    logic [2:0]  addr;
    logic [7:0]  rdata;
    logic [7:0]  gdata;
    logic [7:0]  bdata;
    logic        rwe;
    logic        gwe;
    logic        bwe;
    logic        busy;
    logic [1:0]  line_idx;
    logic        underrun;
    logic        sof_err;
    logic        clr_status;

    int checks = 0;
    int passed = 0;

    logic [24:0] src_q[$];
    logic [26:0] exp_q[$];
    logic [28:0] obs_q[$];
    logic        fire_q = 1'b0;

    fpc_scanline_fill #(
        .WIDTH(8), .HEIGHT(3), .HBITS(3), .VBITS(2), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .linesync(linesync), .framesync(framesync),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_sof(pix_sof),
        .addr(addr), .rdata(rdata), .gdata(gdata), .bdata(bdata),
        .rwe(rwe), .gwe(gwe), .bwe(bwe), .busy(busy), .line_idx(line_idx),
        .underrun(underrun), .sof_err(sof_err), .clr_status(clr_status)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pix(input int n);
        logic [7:0] b;
        b = n[7:0];
        return {b, b ^ 8'h5a, ~b};
    endfunction

    always @(posedge clk) fire_q <= pix_valid && pix_ready;

    // Source: pop the beat accepted at the last edge, then present the next head.
    always @(negedge clk) begin
        if (fire_q && src_q.size() > 0)
            src_q.delete(0);
        pix_valid = src_q.size() > 0;
        pix_data  = (src_q.size() > 0) ? src_q[0][23:0] : 24'h0;
        pix_sof   = (src_q.size() > 0) ? src_q[0][24] : 1'b0;
    end

    always @(negedge clk)
        if (rwe)
            obs_q.push_back({gwe, bwe, addr, rdata, gdata, bdata});

    task automatic load(input int base, input int n, input bit sof_first, input bit expect_wr);
        for (int i = 0; i < n; i++) begin
            src_q.push_back({sof_first && (i == 0), pix(base + i)});
            if (expect_wr)
                exp_q.push_back({3'(i % 8), pix(base + i)});
        end
    endtask

    task automatic line(input bit fs, input bit clr);
        @(negedge clk);
        linesync  = 1'b1;
        framesync = fs;
        repeat (4) @(negedge clk);
        linesync = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr_status = clr;
        @(negedge clk);
        clr_status = 1'b0;
        repeat (3) @(negedge clk);
        framesync = 1'b0;
    endtask

    task automatic wait_writes(input int n);
        for (int i = 0; i < 300; i++) begin
            if (obs_q.size() >= n)
                break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (pix_ready !== 1'b0) $display("FAIL reset_ready got=%b exp=0", pix_ready); else passed++;
        checks++; if ({rwe, gwe, bwe} !== 3'b000) $display("FAIL reset_we got=%b exp=000", {rwe, gwe, bwe}); else passed++;
        checks++; if (addr !== 3'd0) $display("FAIL reset_addr got=%0d exp=0", addr); else passed++;
        checks++; if ({rdata, gdata, bdata} !== 24'h0) $display("FAIL reset_data got=%h exp=0", {rdata, gdata, bdata}); else passed++;
        checks++; if ({busy, underrun, sof_err} !== 3'b000) $display("FAIL reset_status got=%b exp=000", {busy, underrun, sof_err}); else passed++;
        checks++; if (line_idx !== 2'd0) $display("FAIL reset_line_idx got=%0d exp=0", line_idx); else passed++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frame();
        logic [28:0] o;
        logic [26:0] e;
        load(0, 24, 1'b1, 1'b1);
        for (int l = 0; l < 3; l++) begin
            line(l == 0, 1'b0);
            wait_writes(8 * (l + 1));
            checks++; if (line_idx !== 2'(l)) $display("FAIL frame_line_idx got=%0d exp=%0d", line_idx, l); else passed++;
        end
        checks++; if ({busy, pix_ready} !== 2'b00) $display("FAIL frame_end_idle got=%b exp=00", {busy, pix_ready}); else passed++;
        checks++; if ({underrun, sof_err} !== 2'b00) $display("FAIL frame_status got=%b exp=00", {underrun, sof_err}); else passed++;
        checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL frame_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else passed++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== {2'b11, e}) $display("FAIL frame_write got=%h exp=%h", o, {2'b11, e}); else passed++;
        end
    endtask

    task automatic test_sof_hunt();
        logic [28:0] o;
        logic [26:0] e;
        load(100, 3, 1'b0, 1'b0);
        load(24, 24, 1'b1, 1'b1);
        line(1'b1, 1'b0);
        wait_writes(8);
        checks++; if (sof_err !== 1'b1) $display("FAIL hunt_sof_err got=%b exp=1", sof_err); else passed++;
        line(1'b0, 1'b0);
        wait_writes(16);
        line(1'b0, 1'b0);
        wait_writes(24);
        checks++; if (line_idx !== 2'd2) $display("FAIL hunt_line_idx got=%0d exp=2", line_idx); else passed++;
        checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL hunt_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else passed++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== {2'b11, e}) $display("FAIL hunt_write got=%h exp=%h", o, {2'b11, e}); else passed++;
        end
        clr_pulse();
        checks++; if (sof_err !== 1'b0) $display("FAIL hunt_clear got=%b exp=0", sof_err); else passed++;
    endtask

    task automatic test_sof_misplaced();
        logic [28:0] o;
        logic [26:0] e;
        load(50, 8, 1'b1, 1'b1);
        load(58, 5, 1'b0, 1'b1);
        load(70, 24, 1'b1, 1'b1);
        line(1'b1, 1'b0);
        wait_writes(8);
        line(1'b0, 1'b0);
        wait_writes(13);
        repeat (5) @(negedge clk);
        checks++; if (obs_q.size() !== 13) $display("FAIL mis_partial_count got=%0d exp=13", obs_q.size()); else passed++;
        checks++; if (sof_err !== 1'b1) $display("FAIL mis_sof_err got=%b exp=1", sof_err); else passed++;
        checks++; if ({pix_ready, busy} !== 2'b00) $display("FAIL mis_held got=%b exp=00", {pix_ready, busy}); else passed++;
        checks++; if (src_q.size() !== 24) $display("FAIL mis_sof_kept got=%0d exp=24", src_q.size()); else passed++;
        for (int l = 0; l < 3; l++) begin
            line(l == 0, 1'b0);
            wait_writes(13 + 8 * (l + 1));
        end
        checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL mis_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else passed++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== {2'b11, e}) $display("FAIL mis_write got=%h exp=%h", o, {2'b11, e}); else passed++;
        end
        clr_pulse();
    endtask

    task automatic test_underrun();
        logic [28:0] o;
        logic [26:0] e;
        load(140, 3, 1'b1, 1'b1);
        line(1'b1, 1'b0);
        wait_writes(3);
        repeat (20) @(negedge clk);
        checks++; if ({busy, underrun} !== 2'b10) $display("FAIL under_pre got=%b exp=10", {busy, underrun}); else passed++;
        line(1'b0, 1'b1);
        checks++; if (underrun !== 1'b1) $display("FAIL under_set_vs_clr got=%b exp=1", underrun); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL under_busy got=%b exp=0", busy); else passed++;
        checks++; if (obs_q.size() !== 3) $display("FAIL under_count got=%0d exp=3", obs_q.size()); else passed++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== {2'b11, e}) $display("FAIL under_write got=%h exp=%h", o, {2'b11, e}); else passed++;
        end
        clr_pulse();
        checks++; if (underrun !== 1'b0) $display("FAIL under_clear got=%b exp=0", underrun); else passed++;
    endtask

    task automatic test_no_frame();
        int rdy_seen = 0;
        load(90, 2, 1'b0, 1'b0);
        load(180, 24, 1'b1, 1'b1);
        fork
            line(1'b0, 1'b0);
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (pix_ready) rdy_seen++;
            end
        join
        checks++; if (rdy_seen !== 0) $display("FAIL noframe_ready got=%0d exp=0", rdy_seen); else passed++;
        checks++; if (obs_q.size() !== 0) $display("FAIL noframe_writes got=%0d exp=0", obs_q.size()); else passed++;
        checks++; if (src_q.size() !== 26) $display("FAIL noframe_src got=%0d exp=26", src_q.size()); else passed++;
    endtask

    task automatic test_refill();
        logic [28:0] o;
        logic [26:0] e;
        for (int l = 0; l < 3; l++) begin
            line(l == 0, 1'b0);
            wait_writes(8 * (l + 1));
        end
        checks++; if (sof_err !== 1'b1) $display("FAIL refill_sof_err got=%b exp=1", sof_err); else passed++;
        checks++; if (line_idx !== 2'd2) $display("FAIL refill_line_idx got=%0d exp=2", line_idx); else passed++;
        checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL refill_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else passed++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== {2'b11, e}) $display("FAIL refill_write got=%h exp=%h", o, {2'b11, e}); else passed++;
        end
        clr_pulse();
    endtask

    task automatic test_reset_midline();
        logic [28:0] o;
        logic [26:0] e;
        load(120, 24, 1'b1, 1'b0);
        line(1'b1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            if (obs_q.size() >= 3) break;
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({rwe, gwe, bwe, pix_ready, busy} !== 5'b0) $display("FAIL rst_mid_ctrl got=%b exp=00000", {rwe, gwe, bwe, pix_ready, busy}); else passed++;
        checks++; if (addr !== 3'd0) $display("FAIL rst_mid_addr got=%0d exp=0", addr); else passed++;
        checks++; if ({rdata, gdata, bdata} !== 24'h0) $display("FAIL rst_mid_data got=%h exp=0", {rdata, gdata, bdata}); else passed++;
        src_q.delete();
        obs_q.delete();
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        load(200, 24, 1'b1, 1'b1);
        line(1'b0, 1'b0);
        repeat (20) @(negedge clk);
        checks++; if (obs_q.size() !== 0) $display("FAIL rst_mid_nowrite got=%0d exp=0", obs_q.size()); else passed++;
        for (int l = 0; l < 3; l++) begin
            line(l == 0, 1'b0);
            wait_writes(8 * (l + 1));
        end
        checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL rst_mid_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else passed++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o !== {2'b11, e}) $display("FAIL rst_mid_write got=%h exp=%h", o, {2'b11, e}); else passed++;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        linesync   = 1'b0;
        framesync  = 1'b0;
        clr_status = 1'b0;
        pix_valid  = 1'b0;
        pix_data   = 24'h0;
        pix_sof    = 1'b0;
        test_reset();
        test_frame();
        test_sof_hunt();
        test_sof_misplaced();
        test_underrun();
        test_no_frame();
        test_refill();
        test_reset_midline();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fpc_scanline_fill.md
Name: fpc_scanline_fill

Overview:
- Upstream feeder for fpc_hdmi in the system clock domain.
- Takes a valid/ready RGB pixel stream with start-of-frame marking and writes one scanline at a time into the three per-colour scanline RAMs, using fpc_hdmi's clk/addr/rdata/gdata/bdata/rwe/gwe/bwe write port.
- Each fill is paced by fpc_hdmi's linesync/framesync outputs, which are synchronised internally.
- Detects stream misalignment and late fills, then resynchronises at the next frame.

Parameters:
WIDTH, 1600, active pixels per line; number of RAM writes per line
HEIGHT, 900, active lines per frame
HBITS, 11, address width; must match the scanline RAM address width
VBITS, 10, line index width
SYNC_STAGES, 2, flops in each linesync/framesync synchroniser (≥2)

Ports:
clk  in  1  system clock; also drives the scanline RAM write port
rst_n  in  1  asynchronous active-low reset
linesync  in  1  fpc_hdmi hactive (pixclk domain, asynchronous to clk)
framesync  in  1  fpc_hdmi last-line flag (pixclk domain, asynchronous to clk)
pix_valid  in  1  source pixel valid
pix_ready  out  1  pixel accepted when pix_valid && pix_ready
pix_data  in  24  {R[23:16], G[15:8], B[7:0]}
pix_sof  in  1  marks the first pixel of a frame
addr  out  HBITS  scanline RAM write address
rdata, gdata, bdata  out  8 each  write data
rwe, gwe, bwe  out  1 each  write enables; always equal to each other
busy  out  1  high in FILL
line_idx  out  VBITS  line currently or last filled
underrun  out  1  sticky: a fill was still running at the next line boundary
sof_err  out  1  sticky: SOF was misplaced or missing
clr_status  in  1  synchronous clear of underrun and sof_err

Behaviour:
- Reset: clk is the single clock; rst_n is asynchronous and active-low. All outputs go to 0, the FSM enters WAIT_FRAME, and the synchroniser flops and edge register clear to 0.
- Synchronisers: linesync and framesync each pass through SYNC_STAGES flops to give ls_s and fs_s.
  - line_fall = ls_prev & ~ls_s, one clk pulse.
  - line_fall is asserted SYNC_STAGES+1 clk edges after linesync falls.
- FSM:
  - WAIT_FRAME:
    - pix_ready=0.
    - On line_fall with fs_s=1: line_idx←0, pix_cnt←0, hunt←1, go to FILL.
    - line_fall with fs_s=0 is ignored.
  - FILL, while hunt=1:
    - pix_ready=1.
    - Accepted beats with pix_sof=0 are discarded without a write, and sof_err is set once per hunt.
    - The first beat with pix_sof=1 is written at address 0 and clears hunt.
  - FILL, after hunt clears:
    - pix_ready = ~pix_sof. This combinational gating is allowed.
    - Each accepted beat writes at address pix_cnt, then pix_cnt increments.
    - If pix_valid && pix_sof is seen with hunt=0: set sof_err, accept nothing, go to WAIT_FRAME. The SOF beat stays at the source head.
    - When pix_cnt reaches WIDTH:
      - If line_idx = HEIGHT−1, go to WAIT_FRAME.
      - Otherwise go to WAIT_LINE.
  - WAIT_LINE:
    - pix_ready=0.
    - On line_fall: line_idx←line_idx+1, pix_cnt←0, go to FILL.
    - If fs_s=1 at that line_fall, take the WAIT_FRAME entry instead: line_idx←0, hunt←1.
- Underrun:
  - A line_fall while in FILL sets underrun and abandons the line; remaining addresses keep stale data.
  - That same edge is then treated as a WAIT_FRAME entry: line 0 is armed only if fs_s=1; otherwise the FSM goes to WAIT_FRAME.
  - Pixels left over from the abandoned frame are discarded by the next SOF hunt.
- Write port timing:
  - A beat accepted at edge N drives addr, data and we=1 for exactly the cycle after N.
  - we=0 otherwise; addr and data hold their last value.
  - No write is ever issued for a discarded hunt beat.
- Widths: pix_cnt is HBITS+1 bits wide, so WIDTH=2^HBITS is legal. addr = pix_cnt[HBITS−1:0].
- Status: clr_status clears both sticky flags. If clr_status and a set event occur in the same cycle, set wins.
- Simultaneous events:
  - When line_fall coincides with the final beat's acceptance, the beat is written, no underrun is flagged, and the line_fall is honoured from WAIT_LINE (or WAIT_FRAME) on the same edge.
- Rate requirement (integration): f_clk ≥ f_pix and the source sustains its rate. The fill then leads the fpc_hdmi read pointer by about HTOTAL−WIDTH pixel times.

Test Plan:
- Bench setup for all scenarios: WIDTH=8, HEIGHT=3, source always valid, counting data with SOF on pixel 0.
  - First line_fall with framesync=1 → 8 writes, addr 0..7, data 0..7, one per cycle.
  - Two further line_falls → addr 0..7 with data 8..15, then 16..23.
  - line_idx reads 0, 1, 2; FSM returns to WAIT_FRAME.
- Stream begins with 3 non-SOF beats before SOF → those 3 beats are consumed with no write and sof_err=1. First write is at addr 0 carrying the SOF pixel.
- SOF arrives at pixel 5 of line 1 → addr 0..4 written, sof_err=1, pix_ready=0, SOF beat held. The next frame's line 0 starts with that beat at addr 0.
- pix_valid dropped for 20 cycles mid-line, then line_fall arrives → underrun=1. The next frame refills correctly once framesync=1 arrives.
- line_fall with framesync=0 while in WAIT_FRAME → no pix_ready and no writes.
- clr_status pulsed in the same cycle as a new underrun → underrun stays 1.
- rst_n asserted mid-line → all outputs 0 immediately. After release, no writes occur until line_fall with framesync=1.
